mem_loader_16x4: RTL and testbench

Write-side loader for the 16x4 lookup memory. It accepts a burst of 4-bit words over a valid/ready stream and writes them into an internal 16x4 storage array, starting at a programmable base address and wrapping around the address space. It also exposes a registered read port with the same enable/address/data contract as the existing read-only memory, so downstream logic can read back freshly loaded contents. It sits between a configuration source (host or test sequencer) and the lookup consumers.

---
 rtl/mem_loader_pkg.sv | 17 +
 rtl/mem_array_16x4.sv | 44 ++++
 rtl/mem_loader_16x4.sv | 104 ++++++++++
 tb/tb_mem_loader_16x4.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_loader_pkg.sv
// Shared definitions for the 16x4 memory loader: FSM states and default geometry.
package mem_loader_pkg;

  localparam int DEF_DEPTH  = 16;
  localparam int DEF_WIDTH  = 4;
  localparam int DEF_ADDR_W = 4;

  // Largest burst the loader will honour; larger requested counts clamp to this.
  localparam int SAT_COUNT  = DEF_DEPTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mem_array_16x4.sv
// Storage array with one synchronous write port and one registered read port.
// Reads return the pre-write contents on a same-address collision; reset clears everything.
module mem_array_16x4
  import mem_loader_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int WIDTH  = DEF_WIDTH,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_enable,
  input  logic [ADDR_W-1:0] rd_address,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [WIDTH-1:0] rd_data_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_reg[i] <= '0;
      end
    end else if (wr_en) begin
      mem_reg[wr_addr] <= wr_data;
    end
  end

  // Non-blocking read of mem_reg sees the old word when a write hits the same address.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_reg <= '0;
    end else if (rd_enable) begin
      rd_data_reg <= mem_reg[rd_address];
    end
  end

  assign rd_data = rd_data_reg;

endmodule

// File: rtl/mem_loader_16x4.sv
// Burst write loader: streams words into the 16x4 array from a programmable base address,
// wrapping modulo the depth, with a pass-through registered read port.
module mem_loader_16x4
  import mem_loader_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int WIDTH  = DEF_WIDTH,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   count,
  input  logic              wr_valid,
  input  logic [WIDTH-1:0]  wr_data,
  output logic              wr_ready,
  output logic              busy,
  output logic              done,
  input  logic              rd_enable,
  input  logic [ADDR_W-1:0] rd_address,
  output logic [WIDTH-1:0]  rd_data
);

  localparam int               CNT_W   = ADDR_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] ptr_reg, ptr_next;
  logic [CNT_W-1:0]  remaining_reg, remaining_next;
  logic [CNT_W-1:0]  count_sat;
  logic              mem_we;

  assign count_sat = (count > CNT_MAX) ? CNT_MAX : count;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      ptr_reg       <= '0;
      remaining_reg <= '0;
    end else begin
      state_reg     <= state_next;
      ptr_reg       <= ptr_next;
      remaining_reg <= remaining_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    ptr_next       = ptr_reg;
    remaining_next = remaining_reg;
    wr_ready       = 1'b0;
    busy           = 1'b0;
    done           = 1'b0;
    mem_we         = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          ptr_next       = base_addr;
          remaining_next = count_sat;
          state_next     = (count_sat == '0) ? DONE : LOAD;
        end
      end
      LOAD: begin
        wr_ready = 1'b1;
        busy     = 1'b1;
        if (wr_valid) begin
          // Pointer wraps naturally at the top of the address space.
          mem_we         = 1'b1;
          ptr_next       = ptr_reg + 1'b1;
          remaining_next = remaining_reg - 1'b1;
          if (remaining_reg == CNT_ONE) begin
            state_next = DONE;
          end
        end
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  mem_array_16x4 #(
    .DEPTH  (DEPTH),
    .WIDTH  (WIDTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (mem_we),
    .wr_addr    (ptr_reg),
    .wr_data    (wr_data),
    .rd_enable  (rd_enable),
    .rd_address (rd_address),
    .rd_data    (rd_data)
  );

endmodule

// File: tb/tb_mem_loader_16x4.sv
// Randomized self-checking bench for mem_loader_16x4 against a queue-based burst model.
module tb_mem_loader_16x4;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] base_addr;
  logic [4:0] count;
  logic       wr_valid;
  logic [3:0] wr_data;
  logic       wr_ready;
  logic       busy;
  logic       done;
  logic       rd_enable;
  logic [3:0] rd_address;
  logic [3:0] rd_data;

  mem_loader_16x4 dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .base_addr  (base_addr),
    .count      (count),
    .wr_valid   (wr_valid),
    .wr_data    (wr_data),
    .wr_ready   (wr_ready),
    .busy       (busy),
    .done       (done),
    .rd_enable  (rd_enable),
    .rd_address (rd_address),
    .rd_data    (rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: memory image, pending write addresses of the active burst,
  // a flag for the completion cycle, and the expected read register.
  logic [3:0]  m_mem [16];
  int unsigned addr_q [$];
  bit          m_loading;
  bit          m_done;
  logic [3:0]  m_rd;

  int   n_tests;
  int   n_fail;
  int   n_xfer;
  bit   xfer;
  bit   chk_en;
  logic [3:0] burst_data [32];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: check outputs from the previous edge, predict this edge, advance.
  task automatic step();
    int unsigned a;
    int unsigned n;
    if (chk_en) begin
      check_eq("wr_ready", {31'd0, wr_ready}, {31'd0, m_loading});
      check_eq("busy",     {31'd0, busy},     {31'd0, (m_loading || m_done)});
      check_eq("done",     {31'd0, done},     {31'd0, m_done});
      check_eq("rd_data",  {28'd0, rd_data},  {28'd0, m_rd});
    end
    xfer = 1'b0;
    if (rst) begin
      for (int i = 0; i < 16; i++) m_mem[i] = 4'h0;
      m_rd = 4'h0;
      addr_q.delete();
      m_loading = 1'b0;
      m_done = 1'b0;
    end else begin
      if (rd_enable) m_rd = m_mem[rd_address];
      if (m_done) begin
        m_done = 1'b0;
      end else if (m_loading) begin
        if (wr_valid) begin
          a = addr_q.pop_front();
          m_mem[a] = wr_data;
          xfer = 1'b1;
          n_xfer++;
          if (addr_q.size() == 0) begin
            m_loading = 1'b0;
            m_done = 1'b1;
          end
        end
      end else if (start) begin
        n = (count > 5'd16) ? 16 : int'(count);
        for (int i = 0; i < int'(n); i++) addr_q.push_back((int'(base_addr) + i) % 16);
        if (n == 0) m_done = 1'b1;
        else m_loading = 1'b1;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic read_all();
    for (int i = 0; i < 16; i++) begin
      rd_enable = 1'b1;
      rd_address = 4'(i);
      step();
    end
    rd_enable = 1'b0;
    step();
  endtask

  task automatic run_burst(input logic [3:0] base, input logic [4:0] cnt,
                           input int gap_pct, input bit hold_start);
    int k;
    int cyc;
    start = 1'b1;
    base_addr = base;
    count = cnt;
    wr_valid = 1'b0;
    step();
    k = 0;
    cyc = 0;
    while ((m_loading || m_done) && cyc < 300) begin
      start = hold_start;
      base_addr = 4'($urandom);
      count = 5'($urandom);
      wr_valid = ($urandom_range(99) >= gap_pct);
      wr_data = burst_data[k % 32];
      step();
      if (xfer) k++;
      cyc++;
    end
    if (cyc >= 300) check_eq("burst_timeout", cyc, 0);
    start = 1'b0;
    wr_valid = 1'b0;
  endtask

  initial begin
    int x0;
    n_tests = 0; n_fail = 0; n_xfer = 0;
    chk_en = 1'b0;
    rst = 1'b1; start = 1'b0; base_addr = '0; count = '0;
    wr_valid = 1'b0; wr_data = '0; rd_enable = 1'b0; rd_address = '0;
    for (int i = 0; i < 16; i++) m_mem[i] = 4'h0;
    m_loading = 1'b0; m_done = 1'b0; m_rd = 4'h0;
    step();
    step();
    rst = 1'b0;
    chk_en = 1'b1;

    // Reset contents read back as zero.
    read_all();

    // Full 16-word burst, data F down to 0.
    for (int i = 0; i < 32; i++) burst_data[i] = 4'(15 - i);
    x0 = n_xfer;
    run_burst(4'd0, 5'd16, 0, 1'b0);
    check_eq("full_xfers", n_xfer - x0, 16);
    read_all();
    check_eq("full_mem15", {28'd0, m_mem[15]}, 32'h0);

    // Wrapping burst with gaps.
    for (int i = 0; i < 32; i++) burst_data[i] = 4'(i + 1);
    run_burst(4'd14, 5'd4, 50, 1'b0);
    read_all();

    // Empty burst, then oversized burst clamps to 16.
    x0 = n_xfer;
    run_burst(4'd3, 5'd0, 0, 1'b0);
    check_eq("zero_xfers", n_xfer - x0, 0);
    for (int i = 0; i < 32; i++) burst_data[i] = 4'($urandom);
    x0 = n_xfer;
    run_burst(4'd7, 5'd20, 0, 1'b0);
    check_eq("sat_xfers", n_xfer - x0, 16);
    read_all();

    // Same-cycle read/write at address 5.
    burst_data[0] = 4'h3;
    run_burst(4'd5, 5'd1, 0, 1'b0);
    start = 1'b1; base_addr = 4'd5; count = 5'd1; step();
    start = 1'b0; wr_valid = 1'b1; wr_data = 4'hA; rd_enable = 1'b1; rd_address = 4'd5;
    step();
    check_eq("rbw_old", {28'd0, rd_data}, 32'h3);
    wr_valid = 1'b0;
    step();
    check_eq("rbw_new", {28'd0, rd_data}, 32'hA);
    rd_enable = 1'b0; rd_address = 4'd0;
    step();
    step();
    check_eq("rd_hold", {28'd0, rd_data}, 32'hA);

    // Reset after 3 of 8 transfers aborts and clears.
    start = 1'b1; base_addr = 4'd2; count = 5'd8; step();
    start = 1'b0;
    x0 = n_xfer;
    for (int c = 0; c < 50 && (n_xfer - x0) < 3; c++) begin
      wr_valid = 1'b1; wr_data = 4'($urandom); step();
    end
    wr_valid = 1'b0;
    rst = 1'b1; step();
    rst = 1'b0; step();
    step();
    check_eq("abort_no_done", {31'd0, done}, 32'd0);
    read_all();

    // New burst works; start held high during LOAD is ignored.
    for (int i = 0; i < 32; i++) burst_data[i] = 4'($urandom);
    x0 = n_xfer;
    run_burst(4'd9, 5'd5, 30, 1'b1);
    check_eq("hold_xfers", n_xfer - x0, 5);
    read_all();

    // Random traffic.
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(79) == 0);
      start = ($urandom_range(3) == 0);
      base_addr = 4'($urandom);
      count = 5'($urandom);
      wr_valid = ($urandom_range(2) != 0);
      wr_data = 4'($urandom);
      rd_enable = ($urandom_range(1) == 0);
      rd_address = 4'($urandom);
      step();
    end
    rst = 1'b0; start = 1'b0; wr_valid = 1'b0;
    step();
    step();
    read_all();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
